// File: rtl/tx_frame_pkg.sv
// Shared definitions for the transmit frame builder.
// Holds the XGMII control characters, the four block encodings (data and
// control mask, lane 0 in the most significant byte), the FSM state encoding
// and small helpers used to preset the block counters.
package tx_frame_pkg;

  localparam int unsigned NB_DATA_RAW = 64;
  localparam int unsigned NB_CTRL     = 8;
  localparam int unsigned NB_LEN      = 16;
  localparam int unsigned NB_IPG      = 8;
  localparam int unsigned NB_FCNT     = 16;

  // XGMII control characters
  localparam logic [7:0] CHAR_IDLE     = 8'h07;
  localparam logic [7:0] CHAR_START    = 8'hFB;
  localparam logic [7:0] CHAR_TERM     = 8'hFD;
  localparam logic [7:0] CHAR_PREAMBLE = 8'h55;
  localparam logic [7:0] CHAR_SFD      = 8'hD5;

  // Block data words, lane 0 first
  localparam logic [NB_DATA_RAW-1:0] IDLE_DATA  = {8{CHAR_IDLE}};
  localparam logic [NB_DATA_RAW-1:0] START_DATA = {CHAR_START, {6{CHAR_PREAMBLE}}, CHAR_SFD};
  localparam logic [NB_DATA_RAW-1:0] TERM_DATA  = {CHAR_TERM, {7{CHAR_IDLE}}};

  // Block control masks, bit 7 = lane 0
  localparam logic [NB_CTRL-1:0] IDLE_CTRL  = 8'hFF;
  localparam logic [NB_CTRL-1:0] START_CTRL = 8'h80;
  localparam logic [NB_CTRL-1:0] DATA_CTRL  = 8'h00;
  localparam logic [NB_CTRL-1:0] TERM_CTRL  = 8'hFF;

  // Frame FSM state: names the block that the next enabled edge registers
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_TERM  = 2'd3
  } frame_state_e;

  // One transmit block as presented to the 64b/66b encoder
  typedef struct packed {
    logic [NB_DATA_RAW-1:0] data;
    logic [NB_CTRL-1:0]     ctrl;
  } tx_block_t;

  // Block encoding for a given state; payload only matters in ST_DATA
  function automatic tx_block_t block_for_state(input frame_state_e         st,
                                                input logic [NB_DATA_RAW-1:0] payload);
    tx_block_t blk;
    blk.data = IDLE_DATA;
    blk.ctrl = IDLE_CTRL;
    case (st)
      ST_START: begin
        blk.data = START_DATA;
        blk.ctrl = START_CTRL;
      end
      ST_DATA: begin
        blk.data = payload;
        blk.ctrl = DATA_CTRL;
      end
      ST_TERM: begin
        blk.data = TERM_DATA;
        blk.ctrl = TERM_CTRL;
      end
      default: begin
        blk.data = IDLE_DATA;
        blk.ctrl = IDLE_CTRL;
      end
    endcase
    return blk;
  endfunction

  // Gap counter preset: remaining idles after the first one.
  // A gap of 0 is promoted to 1, so the preset is never below 0.
  function automatic logic [NB_IPG-1:0] gap_preset(input logic [NB_IPG-1:0] ipg);
    return (ipg == '0) ? NB_IPG'(0) : ipg - NB_IPG'(1);
  endfunction

  // Payload counter preset: remaining data blocks after the first one.
  function automatic logic [NB_LEN-1:0] len_preset(input logic [NB_LEN-1:0] len);
    return (len == '0) ? NB_LEN'(0) : len - NB_LEN'(1);
  endfunction

endpackage

// File: rtl/frame_block_counter.sv
// Loadable down-counter with enable and zero flag.
// Counts the blocks still to be emitted in the current IDLE gap or DATA run.
// Ports:
//   clk       clock
//   rst       synchronous active-high reset, clears the count
//   load      load load_val (has priority over dec)
//   load_val  preset value
//   dec       decrement by one, saturating at zero
//   zero_c    combinational flag, count is zero
module frame_block_counter #(
  parameter int unsigned NB_CNT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [NB_CNT-1:0] load_val,
  input  logic              dec,
  output logic              zero_c
);

  logic [NB_CNT-1:0] count;

  // Count register: load wins over decrement, decrement stops at zero
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && !zero_c) begin
      count <= count - NB_CNT'(1);
    end
  end

  assign zero_c = (count == '0);

endmodule

// File: rtl/tx_frame_builder.sv
// Transmit frame builder: wraps PRBS payload blocks into XGMII-style frames
// (IDLE gap, START, N x DATA, TERM) for the 64b/66b encoder, and paces the
// payload generator so each payload block is consumed exactly once.
// Ports:
//   i_clock       clock
//   i_reset       synchronous active-high reset
//   i_enable      block-rate tick; nothing advances while low
//   i_data_block  payload block from the generator, lane 0 = [63:56]
//   i_frame_len   payload blocks per frame, sampled when START is registered
//   i_ipg_len     idle blocks between frames, sampled when TERM is registered
//   o_data_req    combinational payload request (generator enable)
//   o_tx_data     registered block data
//   o_tx_ctrl     registered control mask, bit 7 = lane 0
//   o_sof         registered, high with the START block
//   o_eof         registered, high with the TERM block
//   o_frame_cnt   registered count of completed frames, wraps
module tx_frame_builder
  import tx_frame_pkg::*;
(
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic [NB_DATA_RAW-1:0] i_data_block,
  input  logic [NB_LEN-1:0]      i_frame_len,
  input  logic [NB_IPG-1:0]      i_ipg_len,
  output logic                   o_data_req,
  output logic [NB_DATA_RAW-1:0] o_tx_data,
  output logic [NB_CTRL-1:0]     o_tx_ctrl,
  output logic                   o_sof,
  output logic                   o_eof,
  output logic [NB_FCNT-1:0]     o_frame_cnt
);

  frame_state_e      state;
  tx_block_t         blk_c;

  logic              gap_load;
  logic              gap_dec;
  logic [NB_IPG-1:0] gap_load_val;
  logic              gap_zero_c;

  logic              len_load;
  logic              len_dec;
  logic [NB_LEN-1:0] len_load_val;
  logic              len_zero_c;

  // Payload is requested on exactly the edges that register a DATA block,
  // so the generator steps in lockstep with consumption.
  assign o_data_req = i_enable && (state == ST_DATA);

  // Block about to be registered
  assign blk_c = block_for_state(state, i_data_block);

  // Counter control. Each counter holds "blocks left after this one", so a
  // cleared gap counter after reset is the same as a latched gap of 1.
  always_comb begin
    gap_load     = 1'b0;
    gap_dec      = 1'b0;
    gap_load_val = gap_preset(i_ipg_len);
    len_load     = 1'b0;
    len_dec      = 1'b0;
    len_load_val = len_preset(i_frame_len);
    if (i_enable) begin
      gap_load = (state == ST_TERM);
      gap_dec  = (state == ST_IDLE);
      len_load = (state == ST_START);
      len_dec  = (state == ST_DATA);
    end
  end

  // Idle blocks remaining in the inter-frame gap
  frame_block_counter #(
    .NB_CNT (NB_IPG)
  ) u_gap_cnt (
    .clk      (i_clock),
    .rst      (i_reset),
    .load     (gap_load),
    .load_val (gap_load_val),
    .dec      (gap_dec),
    .zero_c   (gap_zero_c)
  );

  // Payload blocks remaining in the current frame
  frame_block_counter #(
    .NB_CNT (NB_LEN)
  ) u_len_cnt (
    .clk      (i_clock),
    .rst      (i_reset),
    .load     (len_load),
    .load_val (len_load_val),
    .dec      (len_dec),
    .zero_c   (len_zero_c)
  );

  // Frame FSM with registered block outputs; everything holds while disabled
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state       <= ST_IDLE;
      o_tx_data   <= IDLE_DATA;
      o_tx_ctrl   <= IDLE_CTRL;
      o_sof       <= 1'b0;
      o_eof       <= 1'b0;
      o_frame_cnt <= '0;
    end else if (i_enable) begin
      o_tx_data <= blk_c.data;
      o_tx_ctrl <= blk_c.ctrl;
      o_sof     <= (state == ST_START);
      o_eof     <= (state == ST_TERM);
      case (state)
        ST_IDLE: begin
          if (gap_zero_c) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          // Zero-length frames skip straight to the terminate block
          state <= (i_frame_len == '0) ? ST_TERM : ST_DATA;
        end
        ST_DATA: begin
          if (len_zero_c) begin
            state <= ST_TERM;
          end
        end
        ST_TERM: begin
          o_frame_cnt <= o_frame_cnt + NB_FCNT'(1);
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Bench for tx_frame_builder: queue-based frame model plus literal checkpoints.
module tb_tx_frame_builder;
  import tx_frame_pkg::*;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [63:0] i_data_block;
  logic [15:0] i_frame_len;
  logic [7:0]  i_ipg_len;
  logic        o_data_req;
  logic [63:0] o_tx_data;
  logic [7:0]  o_tx_ctrl;
  logic        o_sof;
  logic        o_eof;
  logic [15:0] o_frame_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  tx_frame_builder dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_data_block (i_data_block),
    .i_frame_len  (i_frame_len),
    .i_ipg_len    (i_ipg_len),
    .o_data_req   (o_data_req),
    .o_tx_data    (o_tx_data),
    .o_tx_ctrl    (o_tx_ctrl),
    .o_sof        (o_sof),
    .o_eof        (o_eof),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 i_clock = ~i_clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference payload source: steps on every accepted request
  int unsigned gen = 0;
  function automatic logic [63:0] payload(input int unsigned n);
    return 64'hA5A5_0000_0000_0000 | 64'(n);
  endfunction
  assign i_data_block = payload(gen);
  always @(posedge i_clock) begin
    if (i_reset) gen <= 0;
    else if (o_data_req === 1'b1) gen <= gen + 1;
  end

  // Model: a queue of upcoming block kinds, extended as frames are sampled
  typedef enum int {K_IDLE, K_START, K_DATA, K_TERM} kind_e;
  kind_e       q[$];
  logic [63:0] m_data;
  logic [7:0]  m_ctrl;
  logic        m_sof;
  logic        m_eof;
  logic [15:0] m_fcnt;
  int unsigned m_idx;

  always @(posedge i_clock) begin
    kind_e k;
    if (i_reset) begin
      q.delete();
      q.push_back(K_IDLE);
      m_data = 64'h0707_0707_0707_0707;
      m_ctrl = 8'hFF;
      m_sof  = 1'b0;
      m_eof  = 1'b0;
      m_fcnt = 16'h0000;
      m_idx  = 0;
    end else if (i_enable) begin
      if (chk_on) chk("data_req", 64'(o_data_req), 64'(q[0] == K_DATA));
      k = q.pop_front();
      m_sof = (k == K_START);
      m_eof = (k == K_TERM);
      case (k)
        K_IDLE: begin
          m_data = 64'h0707_0707_0707_0707;
          m_ctrl = 8'hFF;
          if (q.size() == 0) q.push_back(K_START);
        end
        K_START: begin
          m_data = 64'hFB55_5555_5555_55D5;
          m_ctrl = 8'h80;
          for (int i = 0; i < int'(i_frame_len); i++) q.push_back(K_DATA);
          q.push_back(K_TERM);
        end
        K_DATA: begin
          m_data = payload(m_idx);
          m_ctrl = 8'h00;
          m_idx++;
        end
        default: begin
          m_data = 64'hFD07_0707_0707_0707;
          m_ctrl = 8'hFF;
          m_fcnt = m_fcnt + 16'd1;
          for (int i = 0; i < ((i_ipg_len == 8'd0) ? 1 : int'(i_ipg_len)); i++)
            q.push_back(K_IDLE);
        end
      endcase
    end else begin
      if (chk_on) chk("data_req_hold", 64'(o_data_req), 64'd0);
    end
  end

  // Registered outputs against the model, every cycle
  always @(negedge i_clock) begin
    if (chk_on) begin
      chk("tx_data", o_tx_data, m_data);
      chk("tx_ctrl", 64'(o_tx_ctrl), 64'(m_ctrl));
      chk("sof", 64'(o_sof), 64'(m_sof));
      chk("eof", 64'(o_eof), 64'(m_eof));
      chk("frame_cnt", 64'(o_frame_cnt), 64'(m_fcnt));
    end
  end

  task automatic wait_sof(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge i_clock);
      if (o_sof === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: sof got 0 required 1 within 64 cycles", tag);
    end
  endtask

  task automatic wait_eof(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge i_clock);
      if (o_eof === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s: eof got 0 required 1 within 64 cycles", tag);
    end
  endtask

  // Hand-derived first frame: IDLE, START, 3 DATA, TERM, 2 IDLE, START
  logic [63:0] lit_data [0:8] = '{64'h0707_0707_0707_0707, 64'hFB55_5555_5555_55D5,
                                  64'hA5A5_0000_0000_0000, 64'hA5A5_0000_0000_0001,
                                  64'hA5A5_0000_0000_0002, 64'hFD07_0707_0707_0707,
                                  64'h0707_0707_0707_0707, 64'h0707_0707_0707_0707,
                                  64'hFB55_5555_5555_55D5};
  logic [7:0]  lit_ctrl [0:8] = '{8'hFF, 8'h80, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'h80};
  logic        lit_sof  [0:8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic        lit_eof  [0:8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [15:0] lit_fcnt [0:8] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd1, 16'd1, 16'd1};

  initial begin
    i_reset     = 1'b1;
    i_enable    = 1'b0;
    i_ipg_len   = 8'd2;
    i_frame_len = 16'd3;
    repeat (3) @(negedge i_clock);
    chk_on = 1'b1;
    chk("rst_data", o_tx_data, 64'h0707_0707_0707_0707);
    chk("rst_ctrl", 64'(o_tx_ctrl), 64'hFF);
    chk("rst_sof", 64'(o_sof), 64'd0);
    chk("rst_eof", 64'(o_eof), 64'd0);
    chk("rst_fcnt", 64'(o_frame_cnt), 64'd0);

    // Basic frame sequence
    i_reset  = 1'b0;
    i_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge i_clock);
      chk("seq_data", o_tx_data, lit_data[i]);
      chk("seq_ctrl", 64'(o_tx_ctrl), 64'(lit_ctrl[i]));
      chk("seq_sof", 64'(o_sof), 64'(lit_sof[i]));
      chk("seq_eof", 64'(o_eof), 64'(lit_eof[i]));
      chk("seq_fcnt", 64'(o_frame_cnt), 64'(lit_fcnt[i]));
    end

    // Zero-length frame: START then TERM
    i_frame_len = 16'd0;
    wait_sof("zero_len_sof");
    @(negedge i_clock);
    chk("zero_len_term", o_tx_data, 64'hFD07_0707_0707_0707);
    chk("zero_len_eof", 64'(o_eof), 64'd1);

    // Consecutive payload over several frames of 4
    i_frame_len = 16'd4;
    repeat (40) @(negedge i_clock);

    // Enable 1,0,0,1 inside a DATA run
    wait_sof("en_sof");
    @(negedge i_clock);
    @(negedge i_clock);
    i_enable = 1'b0;
    repeat (2) @(negedge i_clock);
    i_enable = 1'b1;
    repeat (20) @(negedge i_clock);

    // Reset during the 2nd DATA block of a 5-block frame
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_frame_len = 16'd5;
    i_ipg_len = 8'd1;
    repeat (2) @(negedge i_clock);
    i_reset = 1'b0;
    i_enable = 1'b1;
    wait_sof("abort_sof");
    @(negedge i_clock);
    @(negedge i_clock);
    chk("abort_d2_ctrl", 64'(o_tx_ctrl), 64'h00);
    i_reset = 1'b1;
    i_enable = 1'b0;
    @(negedge i_clock);
    chk("abort_data", o_tx_data, 64'h0707_0707_0707_0707);
    chk("abort_ctrl", 64'(o_tx_ctrl), 64'hFF);
    chk("abort_fcnt", 64'(o_frame_cnt), 64'd0);
    i_reset = 1'b0;
    i_enable = 1'b1;
    @(negedge i_clock);
    chk("abort_next_idle", o_tx_data, 64'h0707_0707_0707_0707);
    @(negedge i_clock);
    chk("abort_restart_sof", 64'(o_sof), 64'd1);

    // Frame counter wrap from a preloaded count
    i_frame_len = 16'd0;
    @(posedge i_clock);
    #2;
    i_enable = 1'b0;
    force dut.o_frame_cnt = 16'hFFFE;
    m_fcnt = 16'hFFFE;
    #1;
    release dut.o_frame_cnt;
    @(negedge i_clock);
    i_enable = 1'b1;
    wait_eof("wrap_eof1");
    chk("fcnt_ffff", 64'(o_frame_cnt), 64'hFFFF);
    wait_eof("wrap_eof2");
    chk("fcnt_wrap", 64'(o_frame_cnt), 64'h0000);
    repeat (5) @(negedge i_clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
